// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman feeder: base encodings, score width default, FSM states.
package sw_pkg;
  localparam int BASE_W      = 2;
  localparam int SCORE_W_DEF = 10;

  localparam logic [BASE_W-1:0] BASE_A = 2'b00;
  localparam logic [BASE_W-1:0] BASE_C = 2'b01;
  localparam logic [BASE_W-1:0] BASE_G = 2'b10;
  localparam logic [BASE_W-1:0] BASE_T = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;
endpackage

// File: rtl/sw_read_buf.sv
// Short-read buffer: written in arrival order during load, read back in any order during shift.
module sw_read_buf
  import sw_pkg::*;
#(
  parameter int N_PE  = 8,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BASE_W-1:0] wr_base,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [BASE_W-1:0] rd_base
);
  // Contents are don't-care after reset, so no reset on the storage.
  logic [BASE_W-1:0] mem_q [N_PE];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_base;
  end

  assign rd_base = mem_q[rd_idx];
endmodule

// File: rtl/sw_array_feeder.sv
// Feeds the PE chain: loads a short read, shifts it in reversed, then streams reference bases and drains.
module sw_array_feeder
  import sw_pkg::*;
#(
  parameter int                N_PE     = 8,
  parameter int                LEN_W    = 4,
  parameter int                REFLEN_W = 16,
  parameter int                SCORE_W  = SCORE_W_DEF,
  parameter logic [BASE_W-1:0] PAD_BASE = BASE_A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    read_len,
  input  logic [REFLEN_W-1:0] ref_len,
  input  logic [BASE_W-1:0]   rd_base,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [BASE_W-1:0]   ref_base,
  input  logic                ref_valid,
  output logic                ref_ready,
  output logic [BASE_W-1:0]   S_out,
  output logic                store_S_out,
  output logic [BASE_W-1:0]   T_out,
  output logic                init_out,
  output logic                init_col,
  output logic [SCORE_W-1:0]  V_out,
  output logic [SCORE_W-1:0]  F_out,
  output logic                busy,
  output logic                done
);
  localparam int IDX_W = $clog2(N_PE);
  localparam int CNT_W = $clog2(N_PE) + 1;
  localparam logic [LEN_W-1:0] N_PE_L = LEN_W'(N_PE);
  localparam logic [CNT_W-1:0] N_PE_C = CNT_W'(N_PE);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [REFLEN_W-1:0]   rlen_q, rlen_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REFLEN_W-1:0]   rcnt_q, rcnt_d;
  logic [BASE_W-1:0]     s_q, s_d, t_q, t_d;
  logic                  store_q, store_d, init_q, init_d, col_q, col_d;
  logic                  wr_en;
  logic [BASE_W-1:0]     buf_rd;
  logic [LEN_W-1:0]      len_clamped;
  logic [CNT_W-1:0]      pad_lim, len_last;
  logic [IDX_W-1:0]      rd_idx;

  assign len_clamped = (read_len == '0 || read_len > N_PE_L) ? N_PE_L : read_len;
  assign len_last    = CNT_W'(len_q) - CNT_1;
  // Beats below pad_lim fill PEs the read does not occupy; the rest walk the buffer top-down.
  assign pad_lim     = N_PE_C - CNT_W'(len_q);
  assign rd_idx      = IDX_W'(N_PE_C - CNT_1 - cnt_q);

  sw_read_buf #(.N_PE(N_PE), .IDX_W(IDX_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (cnt_q[IDX_W-1:0]),
    .wr_base (rd_base),
    .rd_idx  (rd_idx),
    .rd_base (buf_rd)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rlen_d  = rlen_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    s_d     = s_q;
    t_d     = t_q;
    store_d = 1'b0;
    init_d  = 1'b0;
    col_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        len_d   = len_clamped;
        rlen_d  = ref_len;
        cnt_d   = '0;
        rcnt_d  = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: if (rd_valid) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + CNT_1;
        if (cnt_q == len_last) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        store_d = 1'b1;
        s_d     = (cnt_q < pad_lim) ? PAD_BASE : buf_rd;
        cnt_d   = cnt_q + CNT_1;
        if (cnt_q == N_PE_C - CNT_1) begin
          cnt_d   = '0;
          state_d = (rlen_q == '0) ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: if (ref_valid) begin
        t_d    = ref_base;
        init_d = 1'b1;
        col_d  = (rcnt_q == '0);
        rcnt_d = rcnt_q + REFLEN_W'(1);
        if (rcnt_q == rlen_q - REFLEN_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        t_d    = PAD_BASE;
        init_d = 1'b1;
        cnt_d  = cnt_q + CNT_1;
        if (cnt_q == N_PE_C - CNT_W'(2)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      rlen_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      s_q     <= '0;
      t_q     <= '0;
      store_q <= 1'b0;
      init_q  <= 1'b0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rlen_q  <= rlen_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      s_q     <= s_d;
      t_q     <= t_d;
      store_q <= store_d;
      init_q  <= init_d;
      col_q   <= col_d;
    end
  end

  assign S_out       = s_q;
  assign store_S_out = store_q;
  assign T_out       = t_q;
  assign init_out    = init_q;
  assign init_col    = col_q;
  assign V_out       = '0;
  assign F_out       = '1;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign rd_ready    = (state_q == ST_LOAD);
  assign ref_ready   = (state_q == ST_STREAM);
endmodule
